// File: rtl/dcache_pkg.sv
// Shared encodings and address-field positions for the data cache and its memory-side models.
// Purely declarative; no logic, latency or flow control of its own.
package dcache_pkg;

  localparam int DC_LINE_ADDR_LEN = 3;
  localparam int DC_SET_ADDR_LEN  = 3;
  localparam int DC_TAG_ADDR_LEN  = 30 - DC_LINE_ADDR_LEN - DC_SET_ADDR_LEN;
  localparam int DC_LINE_WORDS    = 1 << DC_LINE_ADDR_LEN;
  localparam int DC_SETS          = 1 << DC_SET_ADDR_LEN;

  localparam int DC_WORD_LSB = 2;
  localparam int DC_SET_LSB  = DC_WORD_LSB + DC_LINE_ADDR_LEN;
  localparam int DC_TAG_LSB  = DC_SET_LSB + DC_SET_ADDR_LEN;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_line_ram.sv
// Cache data store: one synchronous write port, one asynchronous read port.
// Write lands at the clock edge; read data follows the read address in the same cycle.
module dcache_line_ram #(
  parameter int AW = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dcache_miss_unit.sv
// Direct-mapped write-back/write-allocate D-cache: hits in zero cycles, misses stall for
// writeback beats + refill beats + 1 cycle; each beat holds mem_req/mem_addr until mem_ack.
module dcache_miss_unit
  import dcache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DC_LINE_ADDR_LEN,
  parameter int SET_ADDR_LEN  = DC_SET_ADDR_LEN
) (
  input  logic        clk,
  input  logic        CpuRst_n,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] miss_count
);

  localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int SETS         = 1 << SET_ADDR_LEN;
  localparam int IDX_W        = SET_ADDR_LEN + LINE_ADDR_LEN;
  localparam logic [LINE_ADDR_LEN-1:0] LAST_BEAT = '1;

  logic [TAG_ADDR_LEN-1:0]  tag_a;
  logic [SET_ADDR_LEN-1:0]  set_a;
  logic [LINE_ADDR_LEN-1:0] word_a;
  logic                     addr_unused;

  assign tag_a       = addr[31 -: TAG_ADDR_LEN];
  assign set_a       = addr[2+LINE_ADDR_LEN+SET_ADDR_LEN-1 -: SET_ADDR_LEN];
  assign word_a      = addr[2+LINE_ADDR_LEN-1 -: LINE_ADDR_LEN];
  assign addr_unused = ^addr[1:0];

  state_t                   state_q, state_d;
  logic [LINE_ADDR_LEN-1:0] beat_q, beat_d;
  logic [TAG_ADDR_LEN-1:0]  vic_tag_q, vic_tag_d;
  logic [TAG_ADDR_LEN-1:0]  req_tag_q, req_tag_d;
  logic [SET_ADDR_LEN-1:0]  req_set_q, req_set_d;
  logic [SETS-1:0]          valid_q, valid_d;
  logic [SETS-1:0]          dirty_q, dirty_d;
  logic [31:0]              miss_count_q, miss_count_d;
  logic [TAG_ADDR_LEN-1:0]  tag_q [SETS];

  logic                     req, hit, tag_we;
  logic                     ram_we;
  logic [IDX_W-1:0]         ram_waddr, ram_raddr;
  logic [31:0]              ram_wdata, ram_rdata;

  assign req = rd_req | wr_req;
  assign hit = req & valid_q[set_a] & (tag_q[set_a] == tag_a) & (state_q == ST_IDLE);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    vic_tag_d    = vic_tag_q;
    req_tag_d    = req_tag_q;
    req_set_d    = req_set_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    miss_count_d = miss_count_q;
    tag_we       = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = {set_a, word_a};
    ram_wdata    = wr_data;
    ram_raddr    = {set_a, word_a};
    case (state_q)
      ST_IDLE: begin
        if (hit && wr_req) begin
          ram_we         = 1'b1;
          dirty_d[set_a] = 1'b1;
        end else if (req && !hit) begin
          vic_tag_d = tag_q[set_a];
          req_tag_d = tag_a;
          req_set_d = set_a;
          beat_d    = '0;
          if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
          state_d   = (valid_q[set_a] && dirty_q[set_a]) ? ST_WB : ST_REFILL;
        end
      end
      ST_WB: begin
        ram_raddr = {req_set_q, beat_q};
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        ram_waddr = {req_set_q, beat_q};
        ram_wdata = mem_rdata;
        if (mem_ack) begin
          ram_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            valid_d[req_set_q] = 1'b1;
            dirty_d[req_set_q] = 1'b0;
            tag_we             = 1'b1;
            state_d            = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!CpuRst_n) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      vic_tag_q    <= '0;
      req_tag_q    <= '0;
      req_set_q    <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      vic_tag_q    <= vic_tag_d;
      req_tag_q    <= req_tag_d;
      req_set_q    <= req_set_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tags are left uninitialised; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (CpuRst_n && tag_we) tag_q[req_set_q] <= req_tag_q;
  end

  dcache_line_ram #(.AW(IDX_W)) u_line_ram (
    .clk_i   (clk),
    .we_i    (ram_we & CpuRst_n),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    mem_addr = '0;
    case (state_q)
      ST_WB:     mem_addr = {vic_tag_q, req_set_q, beat_q, 2'b00};
      ST_REFILL: mem_addr = {req_tag_q, req_set_q, beat_q, 2'b00};
      default:   mem_addr = '0;
    endcase
  end

  assign rd_data    = ram_rdata;
  assign mem_wdata  = ram_rdata;
  assign mem_we     = (state_q == ST_WB);
  assign mem_req    = CpuRst_n & (state_q != ST_IDLE);
  assign miss       = CpuRst_n & ((state_q != ST_IDLE) | (req & ~hit));
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dcache_miss_unit.sv
// Directed bench for dcache_miss_unit with a beat-logging memory model (optional random ack delay).
module tb_dcache_miss_unit;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        CpuRst_n;
  logic        rd_req, wr_req;
  logic [31:0] addr, wr_data, rd_data;
  logic        miss, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, miss_count;

  always #5 clk = ~clk;

  dcache_miss_unit dut (
    .clk(clk), .CpuRst_n(CpuRst_n), .rd_req(rd_req), .wr_req(wr_req),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .miss(miss),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .miss_count(miss_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } beat_t;

  beat_t       log_q[$];
  logic [31:0] mem_model [4096];
  int          max_dly  = 0;
  int          stab_err = 0;
  int          n_chk    = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory: acks after 0..max_dly cycles, logs every beat, checks request stability while pending.
  initial begin : memory
    logic        pending;
    logic [31:0] p_addr;
    logic        p_we;
    int          wait_cnt;
    logic [11:0] idx;
    for (int i = 0; i < 4096; i++) mem_model[i] = 32'h5A00_0000 | (i << DC_WORD_LSB);
    mem_ack = 1'b0; mem_rdata = '0; pending = 1'b0; p_addr = '0; p_we = 1'b0; wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!pending) begin
          pending  = 1'b1;
          p_addr   = mem_addr;
          p_we     = mem_we;
          wait_cnt = int'($urandom_range(max_dly, 0));
        end else if (mem_addr !== p_addr || mem_we !== p_we) begin
          stab_err++;
        end
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          idx     = mem_addr[13:2];
          if (mem_we) begin
            mem_model[idx] = mem_wdata;
            log_q.push_back('{mem_addr, 1'b1, mem_wdata});
          end else begin
            mem_rdata = mem_model[idx];
            log_q.push_back('{mem_addr, 1'b0, mem_model[idx]});
          end
          pending = 1'b0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt--;
        end
      end else begin
        mem_ack = 1'b0;
        pending = 1'b0;
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic first_miss, output logic [31:0] rdat, output int cyc);
    @(negedge clk);
    rd_req = rd; wr_req = wr; addr = a; wr_data = d;
    #1;
    first_miss = miss;
    cyc = 0;
    while (miss && cyc < 400) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (miss) chk("req_timeout", 32'd1, 32'd0);
    rdat = rd_data;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  function automatic int seq_errs(input int first, input int n, input logic [31:0] base,
                                  input logic we);
    int e = 0;
    for (int k = 0; k < n; k++) begin
      if (first + k >= log_q.size()) e++;
      else if (log_q[first+k].addr !== base + 32'(4*k) || log_q[first+k].we !== we) e++;
    end
    return e;
  endfunction

  initial begin : main
    logic        fm;
    logic [31:0] rd;
    int          cyc;
    int          guard;

    CpuRst_n = 1'b0; rd_req = 1'b1; wr_req = 1'b0; addr = 32'h100; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_miss_forced0", {31'd0, miss}, 32'd0);
    chk("rst_memreq0", {31'd0, mem_req}, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    rd_req = 1'b0; CpuRst_n = 1'b1;

    // Cold read
    log_q.delete();
    do_req(1'b1, 1'b0, 32'h100, 32'h0, fm, rd, cyc);
    chk("cold_miss", {31'd0, fm}, 32'd1);
    chk("cold_data", rd, 32'h5A00_0100);
    chk("cold_beats", log_q.size(), 32'd8);
    chk("cold_seq", seq_errs(0, 8, 32'h100, 1'b0), 32'd0);
    chk("cold_latency", cyc, 32'd9);
    chk("cold_count", miss_count, 32'd1);

    // Hit after fill
    log_q.delete();
    do_req(1'b1, 1'b0, 32'h104, 32'h0, fm, rd, cyc);
    chk("hit_nomiss", {31'd0, fm}, 32'd0);
    chk("hit_data", rd, 32'h5A00_0104);
    chk("hit_nobeats", log_q.size(), 32'd0);

    // Write miss allocates the line, then the held store completes
    log_q.delete();
    do_req(1'b0, 1'b1, 32'h2024, 32'h1234_5678, fm, rd, cyc);
    chk("wmiss_miss", {31'd0, fm}, 32'd1);
    chk("wmiss_seq", seq_errs(0, 8, 32'h2020, 1'b0), 32'd0);
    do_req(1'b1, 1'b0, 32'h2024, 32'h0, fm, rd, cyc);
    chk("wmiss_readback", rd, 32'h1234_5678);
    do_req(1'b1, 1'b0, 32'h2028, 32'h0, fm, rd, cyc);
    chk("wmiss_neighbour", rd, 32'h5A00_2028);
    chk("wmiss_count", miss_count, 32'd2);

    // Store hit, then dirty eviction
    do_req(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, fm, rd, cyc);
    chk("sw_hit", {31'd0, fm}, 32'd0);
    log_q.delete();
    do_req(1'b1, 1'b0, 32'h500, 32'h0, fm, rd, cyc);
    chk("evict_beats", log_q.size(), 32'd16);
    chk("evict_wb_seq", seq_errs(0, 8, 32'h100, 1'b1), 32'd0);
    chk("evict_rf_seq", seq_errs(8, 8, 32'h500, 1'b0), 32'd0);
    if (log_q.size() >= 2) begin
      chk("evict_beat0_data", log_q[0].data, 32'hDEAD_BEEF);
      chk("evict_beat1_data", log_q[1].data, 32'h5A00_0104);
    end
    chk("evict_data", rd, 32'h5A00_0500);
    chk("evict_latency", cyc, 32'd17);
    chk("evict_count", miss_count, 32'd3);

    // Clean eviction
    log_q.delete();
    do_req(1'b1, 1'b0, 32'h900, 32'h0, fm, rd, cyc);
    chk("clean_beats", log_q.size(), 32'd8);
    chk("clean_seq", seq_errs(0, 8, 32'h900, 1'b0), 32'd0);
    chk("clean_data", rd, 32'h5A00_0900);

    // Random ack latency with a dirty victim
    max_dly = 5; stab_err = 0;
    log_q.delete();
    do_req(1'b1, 1'b0, 32'h3020, 32'h0, fm, rd, cyc);
    chk("rnd_beats", log_q.size(), 32'd16);
    chk("rnd_wb_seq", seq_errs(0, 8, 32'h2020, 1'b1), 32'd0);
    chk("rnd_rf_seq", seq_errs(8, 8, 32'h3020, 1'b0), 32'd0);
    chk("rnd_stable", stab_err, 32'd0);
    chk("rnd_wb_mem", mem_model[32'h2024 >> 2], 32'h1234_5678);
    chk("rnd_data", rd, 32'h5A00_3020);
    chk("rnd_count", miss_count, 32'd5);
    max_dly = 0;

    // Reset after refill beat 3
    log_q.delete();
    @(negedge clk);
    rd_req = 1'b1; addr = 32'hA00;
    guard = 0;
    while (log_q.size() < 4 && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    if (log_q.size() < 4) chk("midrst_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    chk("midrst_req_before", {31'd0, mem_req}, 32'd1);
    CpuRst_n = 1'b0; rd_req = 1'b0;
    @(posedge clk); #1;
    chk("midrst_memreq0", {31'd0, mem_req}, 32'd0);
    CpuRst_n = 1'b1;
    #1;
    chk("midrst_idle", {31'd0, mem_req}, 32'd0);
    chk("midrst_count", miss_count, 32'd0);
    log_q.delete();
    do_req(1'b1, 1'b0, 32'hA00, 32'h0, fm, rd, cyc);
    chk("midrst_remiss", {31'd0, fm}, 32'd1);
    chk("midrst_refill", log_q.size(), 32'd8);
    chk("midrst_data", rd, 32'h5A00_0A00);

    // Simultaneous rd and wr acts as a store
    do_req(1'b1, 1'b1, 32'hA04, 32'hCAFE_F00D, fm, rd, cyc);
    do_req(1'b1, 1'b0, 32'hA04, 32'h0, fm, rd, cyc);
    chk("rdwr_is_write", rd, 32'hCAFE_F00D);
    chk("final_count", miss_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
